mem_write_queue: RTL and testbench

//   Buffers store requests from the ALU write port (w_valid/w_addr/w_write)
//   and drains them to the memory bus over a valid/ready handshake.

---
 rtl/mem_write_queue_pkg.sv | 15 +
 rtl/mem_write_queue_if.sv | 15 +
 rtl/mem_write_queue_sync_fifo.sv | 77 +++++++
 rtl/mem_write_queue.sv | 90 +++++++++
 tb/tb_mem_write_queue.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_write_queue_pkg.sv
// Types and widths shared between the ALU write port and the memory write queue.
//   WIDTH          : store data width (register width)
//   MEM_ADDR_WIDTH : memory address width
//   mem_write_s    : one queued store {addr, data}
package mem_write_queue_pkg;

   localparam int unsigned WIDTH          = 32;
   localparam int unsigned MEM_ADDR_WIDTH = 16;

   typedef struct packed {
      logic [MEM_ADDR_WIDTH-1:0] addr;
      logic [WIDTH-1:0]          data;
   } mem_write_s;

endpackage

// File: rtl/mem_write_queue_if.sv
// Memory-side valid/ready store bus.
//   valid   : head store presented (master -> slave)
//   payload : head store {addr, data} (master -> slave)
//   ready   : memory accepts head this cycle (slave -> master)
interface mem_write_queue_if;
   import mem_write_queue_pkg::*;

   logic       valid;
   logic       ready;
   mem_write_s payload;

   modport master (output valid, output payload, input ready);
   modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/mem_write_queue_sync_fifo.sv
// Generic first-word fall-through FIFO with registered count/full/empty.
//   clk_i, reset_ni : clock, async active-low reset
//   push_i, wdata_i : write wdata_i at the tail (caller guarantees room)
//   ovw_i           : overwrite the youngest entry with wdata_i in place
//   pop_i           : retire the head (caller guarantees non-empty)
//   rdata_o         : head entry
//   count_o, full_o, empty_o : occupancy status
module sync_fifo #(
   parameter type         elem_t = logic [7:0],
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     push_i,
   input  logic                     ovw_i,
   input  logic                     pop_i,
   input  elem_t                    wdata_i,
   output elem_t                    rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   elem_t            mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             full_q;
   logic             empty_q;

   // Next occupancy; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_i && !push_i) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Storage, pointers and status flags; flags registered from next count.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end else if (ovw_i) begin
            mem_q[wr_ptr_q - PTR_W'(1)] <= wdata_i;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/mem_write_queue.sv
// Store queue between the ALU write port and the memory bus. Stores drain in
// order, first-word fall-through; full_o stalls the ALU, overflow_o records
// any store dropped while full.
//   clk_i, reset_ni      : clock, async active-low reset
//   w_valid_i/w_addr_i/w_write_i : store request from the ALU
//   full_o, empty_o, count_o     : occupancy status
//   overflow_o           : sticky, a store was dropped
//   m                    : memory bus (master side)
// Optional build macro MEM_WRITE_QUEUE_COALESCE_EN: a store to the same
// address as the youngest non-head entry overwrites that entry's data.
module mem_write_queue
   import mem_write_queue_pkg::*;
#(
   parameter int unsigned depth = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_ni,
   input  logic                      w_valid_i,
   input  logic [MEM_ADDR_WIDTH-1:0] w_addr_i,
   input  logic [WIDTH-1:0]          w_write_i,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(depth):0]    count_o,
   output logic                      overflow_o,
   mem_write_queue_if.master         m
);

   localparam int unsigned CNT_W = $clog2(depth) + 1;

   logic       pop_c;
   logic       push_c;
   logic       coalesce_c;
   logic       overflow_q;
   mem_write_s wdata;
   mem_write_s head;

   assign wdata  = '{addr: w_addr_i, data: w_write_i};
   assign pop_c  = !empty_o && m.ready;
   // A full queue still accepts a store when the head retires the same edge.
   assign push_c = w_valid_i && !coalesce_c && (!full_o || pop_c);

`ifdef MEM_WRITE_QUEUE_COALESCE_EN
   logic [MEM_ADDR_WIDTH-1:0] last_addr_q;

   // Youngest entry is the last store pushed; only eligible when it is not
   // the head after any same-cycle pop, so m_* never changes under the bus.
   assign coalesce_c = w_valid_i && (w_addr_i == last_addr_q) &&
                       ((count_o - CNT_W'(pop_c)) >= CNT_W'(2));

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         last_addr_q <= '0;
      end else if (push_c) begin
         last_addr_q <= w_addr_i;
      end
   end
`else
   assign coalesce_c = 1'b0;
`endif

   sync_fifo #(
      .elem_t (mem_write_s),
      .DEPTH  (depth)
   ) u_fifo (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .push_i   (push_c),
      .ovw_i    (coalesce_c),
      .pop_i    (pop_c),
      .wdata_i  (wdata),
      .rdata_o  (head),
      .count_o  (count_o),
      .full_o   (full_o),
      .empty_o  (empty_o)
   );

   // Sticky drop flag: store while full with no slot freed this edge.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         overflow_q <= 1'b0;
      end else if (w_valid_i && full_o && !pop_c && !coalesce_c) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow_o = overflow_q;
   assign m.valid    = !empty_o;
   assign m.payload  = head;

endmodule

// File: tb/tb_mem_write_queue.sv
// Self-checking bench for mem_write_queue: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_write_queue;
   import mem_write_queue_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk_i    = 1'b0;
   logic        reset_ni = 1'b0;
   logic        w_valid_i = 1'b0;
   logic [15:0] w_addr_i  = '0;
   logic [31:0] w_write_i = '0;
   logic        full_o;
   logic        empty_o;
   logic [2:0]  count_o;
   logic        overflow_o;

   mem_write_queue_if bus();

   mem_write_queue #(.depth(DEPTH)) dut (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .w_valid_i  (w_valid_i),
      .w_addr_i   (w_addr_i),
      .w_write_i  (w_write_i),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .count_o    (count_o),
      .overflow_o (overflow_o),
      .m          (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   mem_write_s  mq[$];
   bit          m_ovf = 1'b0;
   logic [15:0] drained_a[$];
   logic [31:0] drained_d[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare against the model at mid-cycle, then advance the model by the
   // transaction the current inputs will perform at the next rising edge.
   always @(negedge clk_i) begin
      bit do_pop;
      bit do_push;
      bit merge;
      if (!reset_ni) begin
         mq.delete();
         m_ovf = 1'b0;
         chk("rst_valid",    64'(bus.valid),        64'(0));
         chk("rst_count",    64'(count_o),          64'(0));
         chk("rst_empty",    64'(empty_o),          64'(1));
         chk("rst_full",     64'(full_o),           64'(0));
         chk("rst_overflow", 64'(overflow_o),       64'(0));
         chk("rst_addr",     64'(bus.payload.addr), 64'(0));
         chk("rst_data",     64'(bus.payload.data), 64'(0));
      end else begin
         chk("valid",    64'(bus.valid),  64'(mq.size() != 0));
         chk("count",    64'(count_o),    64'(mq.size()));
         chk("full",     64'(full_o),     64'(mq.size() == DEPTH));
         chk("empty",    64'(empty_o),    64'(mq.size() == 0));
         chk("overflow", 64'(overflow_o), 64'(m_ovf));
         if (mq.size() != 0) begin
            chk("head_addr", 64'(bus.payload.addr), 64'(mq[0].addr));
            chk("head_data", 64'(bus.payload.data), 64'(mq[0].data));
         end
         if (bus.valid && bus.ready) begin
            drained_a.push_back(bus.payload.addr);
            drained_d.push_back(bus.payload.data);
         end
         do_pop  = (mq.size() != 0) && bus.ready;
         do_push = w_valid_i;
         merge   = 1'b0;
`ifdef MEM_WRITE_QUEUE_COALESCE_EN
         if (do_push && (mq.size() - int'(do_pop)) >= 2 && mq[$].addr == w_addr_i) begin
            mq[$].data = w_write_i;
            merge = 1'b1;
         end
`endif
         if (do_push && !merge && mq.size() == DEPTH && !do_pop) begin
            m_ovf   = 1'b1;
            do_push = 1'b0;
         end
         if (do_pop) void'(mq.pop_front());
         if (do_push && !merge) mq.push_back('{addr: w_addr_i, data: w_write_i});
      end
   end

   task automatic drive(input logic v, input logic [15:0] a, input logic [31:0] d, input logic r);
      w_valid_i = v;
      w_addr_i  = a;
      w_write_i = d;
      bus.ready = r;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      reset_ni  = 1'b0;
      w_valid_i = 1'b0;
      bus.ready = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      drained_a.delete();
      drained_d.delete();
   endtask

   task automatic drain();
      int n = 0;
      while (!empty_o && n < 32) begin
         drive(1'b0, 16'h0, 32'h0, 1'b1);
         n++;
      end
      chk("drain_done", 64'(empty_o), 64'(1));
      bus.ready = 1'b0;
   endtask

   task automatic check_drained(input int exp_q[$]);
      chk("drain_len", 64'(drained_a.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < drained_a.size(); i++) begin
         chk("drain_addr", 64'(drained_a[i]), 64'(exp_q[i]));
      end
   endtask

   initial begin
      int exp_q[$];
      int n_before;
      bus.ready = 1'b0;
      do_reset();

      // Single store presented next cycle and held while not accepted.
      drive(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 64'(bus.valid),        64'(1));
         chk("hold_addr",  64'(bus.payload.addr), 64'h0010);
         chk("hold_data",  64'(bus.payload.data), 64'hDEADBEEF);
         drive(1'b0, 16'h0, 32'h0, 1'b0);
      end
      drain();
      exp_q = '{16};
      check_drained(exp_q);

      // Fill past capacity: fifth store dropped, overflow raised.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 16'(i), 32'(i * 100), 1'b0);
         if (i == 4) chk("full_after4", 64'(full_o), 64'(1));
      end
      chk("ovf_set",   64'(overflow_o), 64'(1));
      chk("ovf_count", 64'(count_o),    64'(4));
      drain();
      exp_q = '{1, 2, 3, 4};
      check_drained(exp_q);

      // Push into a full queue while the head retires.
      do_reset();
      for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 32'(i), 1'b0);
      drive(1'b1, 16'd9, 32'd9, 1'b1);
      chk("pp_count", 64'(count_o),    64'(4));
      chk("pp_ovf",   64'(overflow_o), 64'(0));
      drain();
      exp_q = '{1, 2, 3, 4, 9};
      check_drained(exp_q);

      // Pass-through with memory always ready.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'(i), 32'(i + 32'h100), 1'b1);
         chk("pt_valid", 64'(bus.valid), 64'(1));
         chk("pt_count", 64'(count_o),   64'(1));
      end
      drain();
      exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
      check_drained(exp_q);

      // Asynchronous reset mid-drain with three entries and overflow set.
      do_reset();
      for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i), 32'(i), 1'b0);
      drive(1'b0, 16'h0, 32'h0, 1'b1);
      chk("mid_count", 64'(count_o), 64'(3));
      reset_ni = 1'b0;
      #1;
      chk("async_valid", 64'(bus.valid),  64'(0));
      chk("async_count", 64'(count_o),    64'(0));
      chk("async_ovf",   64'(overflow_o), 64'(0));
      n_before = drained_a.size();
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      for (int i = 0; i < 5; i++) drive(1'b0, 16'h0, 32'h0, 1'b1);
      chk("no_replay", 64'(drained_a.size()), 64'(n_before));
      chk("no_replay_valid", 64'(bus.valid), 64'(0));

`ifdef MEM_WRITE_QUEUE_COALESCE_EN
      do_reset();
      drive(1'b1, 16'd5, 32'hA, 1'b0);
      drive(1'b1, 16'd6, 32'hB, 1'b0);
      drive(1'b1, 16'd6, 32'hC, 1'b0);
      chk("co_count", 64'(count_o), 64'(2));
      drain();
      exp_q = '{5, 6};
      check_drained(exp_q);
      if (drained_d.size() == 2) begin
         chk("co_data0", 64'(drained_d[0]), 64'hA);
         chk("co_data1", 64'(drained_d[1]), 64'hC);
      end
      do_reset();
      drive(1'b1, 16'd5, 32'hA, 1'b0);
      drive(1'b1, 16'd5, 32'hD, 1'b0);
      chk("co_head_count", 64'(count_o), 64'(2));
      drain();
`endif

      // Randomized traffic over a small address range.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         drive(1'($urandom_range(0, 9) < 7), 16'($urandom_range(0, 3)), 32'($urandom),
               1'($urandom_range(0, 1)));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
